// File: rtl/spi_io_pkg.sv
// Shared types and constants for the quad-SPI I/O bridge.
package spi_io_pkg;
  localparam int NIBBLE_W = 4;
  localparam int BYTE_W = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    PHASE_HIGH,
    PHASE_LOW
  } phase_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for one asynchronous pin with rise/fall detection
// on the synchronised level.
module sync_edge_detect
  import spi_io_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = sync_out & ~prev;
  assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_qio_frontend.sv
// Quad-SPI (CPOL=0/CPHA=0) pin front-end: oversampled sync, nibble<->byte
// assembly and serialisation, frame framing, all in the clk domain.
module spi_qio_frontend
  import spi_io_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
  parameter int MIN_OVERSAMPLE = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    cs,
  input  logic    sclk,
  input  nibble_t d_in,
  output nibble_t d_out,
  output logic    d_oe,
  output logic    frame_active,
  output logic    frame_start,
  output logic    frame_end,
  output logic    frame_error,
  output byte_t   rx_data,
  output logic    rx_valid,
  output logic    rx_first,
  input  logic    tx_mode,
  input  byte_t   tx_data,
  input  logic    tx_valid,
  output logic    tx_ready
);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_sync, sclk_rise, sclk_fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .async_in(cs),
    .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .async_in(sclk),
    .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Data uses the same depth as sclk so the sample lines up with sclk_rise.
  nibble_t d_sync_q [SYNC_STAGES];

  // NOTE: the small synchroniser array is reset element by element; it is a
  // register bank, not a RAM, so resetting it costs nothing special.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
    end else begin
      d_sync_q[0] <= d_in;
      for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
    end
  end

  logic    armed, first_pending, underrun, dir_q, hold_full, end_pending;
  phase_t  phase;
  nibble_t rx_hi, tx_lo;
  byte_t   hold_reg;

  // A same-cycle cs_fall takes effect before any sclk edge; cs_rise masks it.
  logic   start, stop, act_now, first_now, eff_tx, rx_evt, tx_evt;
  phase_t ph_now;

  assign start     = cs_fall & armed;
  assign stop      = cs_rise & frame_active;
  assign act_now   = (frame_active | start) & ~stop;
  assign ph_now    = start ? PHASE_HIGH : phase;
  assign first_now = start | first_pending;
  assign eff_tx    = (ph_now == PHASE_HIGH) ? tx_mode : dir_q;
  assign rx_evt    = act_now & sclk_rise & ~eff_tx;
  assign tx_evt    = act_now & sclk_fall & eff_tx;
  assign tx_ready  = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed         <= 1'b0;
      frame_active  <= 1'b0;
      first_pending <= 1'b0;
      underrun      <= 1'b0;
      dir_q         <= 1'b0;
      hold_full     <= 1'b0;
      end_pending   <= 1'b0;
      phase         <= PHASE_HIGH;
      rx_hi         <= '0;
      tx_lo         <= '0;
      hold_reg      <= '0;
      d_out         <= '0;
      d_oe          <= 1'b0;
      frame_start   <= 1'b0;
      frame_end     <= 1'b0;
      frame_error   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_first      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      rx_valid    <= 1'b0;
      rx_first    <= 1'b0;

      if (cs_sync) armed <= 1'b1;

      if (end_pending) begin
        end_pending <= 1'b0;
        frame_end   <= 1'b1;
        frame_error <= ((phase == PHASE_LOW) && !dir_q) || underrun;
      end

      if (start) begin
        frame_start   <= 1'b1;
        frame_active  <= 1'b1;
        phase         <= PHASE_HIGH;
        first_pending <= 1'b1;
        underrun      <= 1'b0;
      end

      if (stop) begin
        frame_active <= 1'b0;
        d_oe         <= 1'b0;
        end_pending  <= 1'b1;
      end

      if (rx_evt) begin
        if (ph_now == PHASE_HIGH) begin
          rx_hi <= d_sync_q[SYNC_STAGES-1];
          dir_q <= 1'b0;
          phase <= PHASE_LOW;
        end else begin
          rx_data       <= {rx_hi, d_sync_q[SYNC_STAGES-1]};
          rx_valid      <= 1'b1;
          rx_first      <= first_now;
          first_pending <= 1'b0;
          phase         <= PHASE_HIGH;
        end
      end

      if (tx_evt) begin
        d_oe <= 1'b1;
        if (ph_now == PHASE_HIGH) begin
          dir_q <= 1'b1;
          phase <= PHASE_LOW;
          if (hold_full) begin
            d_out     <= hold_reg[BYTE_W-1:NIBBLE_W];
            tx_lo     <= hold_reg[NIBBLE_W-1:0];
            hold_full <= 1'b0;
          end else begin
            d_out    <= '0;
            tx_lo    <= '0;
            underrun <= 1'b1;
          end
        end else begin
          d_out <= tx_lo;
          phase <= PHASE_HIGH;
        end
      end

      // Only loads into an empty holding register, so it never races the move.
      if (tx_valid && !hold_full) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  localparam int HALF_PERIOD = MIN_OVERSAMPLE / 2;

  logic       sclk_level_q;
  logic [7:0] sclk_level_cnt;

  // Each sclk level must last at least half the minimum oversampling ratio.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_level_q   <= 1'b0;
      sclk_level_cnt <= '1;
    end else begin
      sclk_level_q <= sclk_sync;
      if (sclk_sync != sclk_level_q) begin
        assert (int'(sclk_level_cnt) >= HALF_PERIOD - 1);
        sclk_level_cnt <= '0;
      end else if (sclk_level_cnt != '1) begin
        sclk_level_cnt <= sclk_level_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_qio_frontend.sv
// Scoreboard bench for spi_qio_frontend: a bus master drives nibbles at
// clk/sclk = 8 while a monitor checks rx bytes, tx nibbles and frame ends.
module tb_spi_qio_frontend;
  import spi_io_pkg::*;

  logic    clk = 1'b0;
  logic    reset, cs, sclk;
  nibble_t d_in, d_out;
  logic    d_oe, frame_active, frame_start, frame_end, frame_error;
  byte_t   rx_data;
  logic    rx_valid, rx_first, tx_mode, tx_valid, tx_ready;
  byte_t   tx_data;

  spi_qio_frontend dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .frame_active(frame_active),
    .frame_start(frame_start), .frame_end(frame_end), .frame_error(frame_error),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
    .tx_mode(tx_mode), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int end_cnt = 0;
  bit oe_seen = 1'b0;

  typedef struct packed {
    logic  first;
    byte_t data;
  } rx_exp_t;

  rx_exp_t exp_rx[$];
  nibble_t exp_dout[$];
  logic    exp_err[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Monitor: pops expectations when the DUT strobes an output.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_start) start_cnt++;
      if (d_oe) oe_seen = 1'b1;
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
        else check("rx_byte", {rx_first, rx_data}, exp_rx.pop_front());
      end
      if (frame_end) begin
        end_cnt++;
        if (exp_err.size() == 0) check("end_unexpected", exp_err.size(), 1);
        else check("frame_error", frame_error, exp_err.pop_front());
      end
    end
  end

  // One sclk period: master drives drv (sclk low), optionally checks the
  // slave nibble before the rising edge, then falls; last also raises cs.
  task automatic nib(input nibble_t drv, input bit chk, input bit last);
    d_in = drv;
    repeat (4) @(negedge clk);
    if (chk) begin
      if (exp_dout.size() == 0) check("dout_unexpected", exp_dout.size(), 1);
      else begin
        check("d_out", d_out, exp_dout.pop_front());
        check("d_oe_tx", d_oe, 1);
      end
    end
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    if (last) cs = 1'b1;
  endtask

  task automatic offer(input byte_t b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("tx_accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic frame_begin();
    oe_seen = 1'b0;
    tx_mode = 1'b0;
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_finish();
    repeat (8) @(negedge clk);
    tx_mode = 1'b0;
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int starts_before, ends_before;

  initial begin
    reset = 1'b1; cs = 1'b0; sclk = 1'b0; d_in = '0;
    tx_mode = 1'b0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {d_out, d_oe, frame_active, frame_start, frame_end, frame_error,
           rx_data, rx_valid, rx_first, tx_ready},
          {4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    reset = 1'b0;

    // Released mid-frame: unarmed, so nothing is recognised.
    nib(4'h3, 0, 0); nib(4'hC, 0, 0); nib(4'hA, 0, 0); nib(4'h7, 0, 0);
    repeat (6) @(negedge clk);
    check("unarmed_start", start_cnt, 0);
    check("unarmed_active", frame_active, 0);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // Plain receive of two bytes.
    frame_begin();
    check("start_once", start_cnt, 1);
    check("active", frame_active, 1);
    exp_rx.push_back('{1'b1, 8'h50});
    exp_rx.push_back('{1'b0, 8'h51});
    exp_err.push_back(1'b0);
    nib(4'h5, 0, 0); nib(4'h0, 0, 0); nib(4'h5, 0, 0); nib(4'h1, 0, 1);
    frame_finish();
    check("inactive_after_end", frame_active, 0);

    // Command then two back-to-back transmit bytes.
    frame_begin();
    exp_rx.push_back('{1'b1, 8'h51});
    exp_dout.push_back(4'hA); exp_dout.push_back(4'h5);
    exp_dout.push_back(4'h3); exp_dout.push_back(4'hC);
    exp_err.push_back(1'b0);
    fork
      begin offer(8'hA5); offer(8'h3C); end
      begin
        nib(4'h5, 0, 0);
        tx_mode = 1'b1;
        nib(4'h1, 0, 0);
        nib(4'h0, 1, 0); nib(4'h0, 1, 0); nib(4'h0, 1, 0); nib(4'h0, 1, 1);
      end
    join
    frame_finish();
    check("d_oe_released", d_oe, 0);

    // Second byte never offered: underrun.
    frame_begin();
    exp_rx.push_back('{1'b1, 8'h51});
    exp_dout.push_back(4'h9); exp_dout.push_back(4'h6);
    exp_dout.push_back(4'h0); exp_dout.push_back(4'h0);
    exp_err.push_back(1'b1);
    fork
      offer(8'h96);
      begin
        nib(4'h5, 0, 0);
        tx_mode = 1'b1;
        nib(4'h1, 0, 0);
        nib(4'h0, 1, 0); nib(4'h0, 1, 0); nib(4'h0, 1, 0); nib(4'h0, 1, 1);
      end
    join
    frame_finish();

    // Odd nibble count: one byte, then error.
    frame_begin();
    exp_rx.push_back('{1'b1, 8'h7E});
    exp_err.push_back(1'b1);
    nib(4'h7, 0, 0); nib(4'hE, 0, 0); nib(4'h2, 0, 1);
    frame_finish();
    check("oe_idle_rx", oe_seen, 0);

    // Reset in the middle of a transmit.
    frame_begin();
    exp_rx.push_back('{1'b1, 8'h51});
    exp_dout.push_back(4'hA);
    fork
      begin offer(8'hA5); offer(8'h3C); end
      begin
        nib(4'h5, 0, 0);
        tx_mode = 1'b1;
        nib(4'h1, 0, 0);
        nib(4'h0, 1, 0);
      end
    join
    check("hold_loaded", tx_ready, 0);
    check("oe_before_reset", d_oe, 1);
    starts_before = start_cnt;
    ends_before = end_cnt;
    reset = 1'b1;
    #1;
    check("reset_d_oe", d_oe, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_active", frame_active, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nib(4'h0, 0, 0); nib(4'h0, 0, 1);
    frame_finish();
    check("no_end_after_reset", end_cnt, ends_before);
    check("no_start_after_reset", start_cnt, starts_before);

    check("rx_left", exp_rx.size(), 0);
    check("dout_left", exp_dout.size(), 0);
    check("end_left", exp_err.size(), 0);
    check("starts_total", start_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
